exu_ctrl: RTL and testbench

Execute-stage controller that sequences the single-cycle-registered ALU and the iterative multiply/divide unit (MDU) for one in-flight instruction at a time. It sits between decode/issue (upstream valid/ready) and writeback (downstream valid/ready). It owns the operand and result registers, drives ALU and MDU handshakes, absorbs pipeline flushes safely, and counts retired operations.

---
 rtl/exu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_exu_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exu_ctrl.sv
// Execute-stage controller: issues one op at a time to the ALU or the iterative MDU,
// holds the result for writeback, absorbs flushes and counts retired ops.
module exu_ctrl #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned MDUOP_W = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_mdu,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [MDUOP_W-1:0] in_mduop,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [4:0]         in_rd,

  output logic               alu_valid,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_data,
  input  logic               alu_data_ok,

  output logic               mdu_start,
  output logic [MDUOP_W-1:0] mdu_op,
  output logic [DATA_W-1:0]  mdu_a,
  output logic [DATA_W-1:0]  mdu_b,
  input  logic               mdu_done,
  input  logic [DATA_W-1:0]  mdu_result,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [4:0]         out_rd,

  output logic               busy,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StAluWait,
    StMduWait,
    StHold,
    StDrain
  } state_e;

  state_e state_q, state_d;

  // Set for the first cycle of a wait state: gates mdu_start and masks a stale alu_data_ok.
  logic first_q, first_d;

  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [MDUOP_W-1:0] mduop_q, mduop_d;
  logic [DATA_W-1:0]  opa_q, opa_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [4:0]         rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic accept;
  logic capture_alu;
  logic capture_mdu;
  logic retire;

  // Next-state; flush is checked first so it beats every other transition.
  always_comb begin
    state_d     = state_q;
    first_d     = 1'b0;
    accept      = 1'b0;
    capture_alu = 1'b0;
    capture_mdu = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!flush && in_valid) begin
          accept  = 1'b1;
          first_d = 1'b1;
          state_d = in_is_mdu ? StMduWait : StAluWait;
        end
      end
      StAluWait: begin
        if (flush) begin
          state_d = StIdle;
        end else if (!first_q && alu_data_ok) begin
          capture_alu = 1'b1;
          state_d     = StHold;
        end
      end
      StMduWait: begin
        if (flush) begin
          // An op already completing this cycle leaves nothing to drain.
          state_d = mdu_done ? StIdle : StDrain;
        end else if (mdu_done) begin
          capture_mdu = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (flush) begin
          state_d = StIdle;
        end else if (out_ready) begin
          retire  = 1'b1;
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (mdu_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    aluop_d = aluop_q;
    mduop_d = mduop_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rd_d    = rd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    if (accept) begin
      aluop_d = in_aluop;
      mduop_d = in_mduop;
      opa_d   = in_a;
      opb_d   = in_b;
      rd_d    = in_rd;
    end
    if (capture_alu) begin
      res_d = alu_data;
    end else if (capture_mdu) begin
      res_d = mdu_result;
    end
    if (retire) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      first_q <= 1'b0;
      aluop_q <= '0;
      mduop_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      aluop_q <= aluop_d;
      mduop_q <= mduop_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign alu_valid  = (state_q == StAluWait);
  assign mdu_start  = (state_q == StMduWait) && first_q;
  assign out_valid  = (state_q == StHold);
  assign busy       = (state_q != StIdle);

  assign alu_op     = aluop_q;
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign mdu_op     = mduop_q;
  assign mdu_a      = opa_q;
  assign mdu_b      = opb_q;
  assign out_data   = res_q;
  assign out_rd     = rd_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_exu_ctrl.sv
// Bench for exu_ctrl: behavioural ALU/MDU environment plus a per-transaction timeline model.
module tb_exu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_mdu = 1'b0;
  logic [4:0]  in_aluop = '0;
  logic [3:0]  in_mduop = '0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        alu_valid;
  logic [4:0]  alu_op;
  logic [63:0] alu_a, alu_b, alu_data;
  logic        alu_data_ok;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [63:0] mdu_a, mdu_b, mdu_result;
  logic        mdu_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        busy;
  logic [3:0]  retire_cnt;

  logic        alu_ok_q = 1'b0;
  logic        force_ok = 1'b0;
  logic [63:0] alu_env;

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;

  exu_ctrl #(
    .DATA_W (64),
    .ALUOP_W(5),
    .MDUOP_W(4),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_mdu  (in_is_mdu),
    .in_aluop   (in_aluop),
    .in_mduop   (in_mduop),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .alu_valid  (alu_valid),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_data   (alu_data),
    .alu_data_ok(alu_data_ok),
    .mdu_start  (mdu_start),
    .mdu_op     (mdu_op),
    .mdu_a      (mdu_a),
    .mdu_b      (mdu_b),
    .mdu_done   (mdu_done),
    .mdu_result (mdu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .busy       (busy),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // ALU environment: done flag is a registered copy of alu_valid; force_ok injects a stale one.
  always @(posedge clk) alu_ok_q <= reset ? 1'b0 : alu_valid;
  assign alu_env     = (alu_op == 5'd0) ? alu_a + alu_b : (alu_a ^ alu_b) + 64'(alu_op);
  assign alu_data    = force_ok ? 64'hDEAD : alu_env;
  assign alu_data_ok = alu_ok_q | force_ok;
  assign mdu_result  = mdu_done ? mdu_a * mdu_b + 64'(mdu_op) : 64'd0;

  function automatic logic [63:0] ref_res(input bit is_mdu, input logic [4:0] aop,
                                          input logic [3:0] mop, input logic [63:0] a,
                                          input logic [63:0] b);
    if (is_mdu) return a * b + 64'(mop);
    return (aop == 5'd0) ? a + b : (a ^ b) + 64'(aop);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One op issued in the current cycle T. Cycle n is T+1+n. lat: mdu_done at n=lat.
  // f: flush at cycle n=f (-1: none). bp: out_ready=0 cycles before acceptance.
  task automatic run_op(input bit is_mdu, input logic [4:0] aop, input logic [3:0] mop,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input int lat, input int f, input int bp, input bit stale);
    logic [63:0] exp_res;
    int vstart, last;
    bit ov_exp;
    exp_res = ref_res(is_mdu, aop, mop, a, b);
    vstart  = is_mdu ? lat + 1 : 2;
    if (f >= 0 && f < vstart) last = is_mdu ? lat : f;
    else if (f >= 0)          last = f;
    else                      last = vstart + bp;

    chk("in_ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1; in_is_mdu = is_mdu; in_aluop = aop; in_mduop = mop;
    in_a = a; in_b = b; in_rd = rd;
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_rd = ~rd; in_aluop = ~aop; in_mduop = ~mop;
    chk("latched_a", is_mdu ? mdu_a : alu_a, a);
    chk("latched_b", is_mdu ? mdu_b : alu_b, b);
    chk("latched_op", is_mdu ? 64'(mdu_op) : 64'(alu_op), is_mdu ? 64'(mop) : 64'(aop));

    for (int n = 0; n <= last; n++) begin
      flush     = (n == f);
      mdu_done  = is_mdu && (n == lat);
      out_ready = (f < 0) && (n == vstart + bp);
      force_ok  = stale && (n == 0);
      ov_exp    = (n >= vstart);
      chk("busy", busy, 1'b1);
      chk("in_ready_busy", in_ready, 1'b0);
      chk("alu_valid", alu_valid, !is_mdu && n < 2);
      chk("mdu_start", mdu_start, is_mdu && n == 0);
      chk("out_valid", out_valid, ov_exp);
      if (ov_exp) begin
        chk("out_data", out_data, exp_res);
        chk("out_rd", out_rd, rd);
        chk("retire_hold", retire_cnt, 64'(model_cnt % 16));
      end
      tick();
    end
    flush = 1'b0; mdu_done = 1'b0; out_ready = 1'b0; force_ok = 1'b0;
    if (f < 0) model_cnt++;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("retire_cnt", retire_cnt, 64'(model_cnt % 16));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);
    reset = 1'b0;
    tick();

    // Directed scenarios.
    run_op(1'b0, 5'd0, 4'd0, 64'd5, 64'd7, 5'd3, 0, -1, 0, 1'b0);
    run_op(1'b1, 5'd0, 4'd0, 64'd6, 64'd7, 5'd9, 4, -1, 3, 1'b0);
    run_op(1'b1, 5'd0, 4'd2, 64'd3, 64'd4, 5'd1, 5, 1, 0, 1'b0);
    run_op(1'b1, 5'd0, 4'd1, 64'd8, 64'd9, 5'd2, 2, 2, 0, 1'b0);
    run_op(1'b1, 5'd0, 4'd1, 64'd8, 64'd9, 5'd4, 0, -1, 0, 1'b0);
    run_op(1'b0, 5'd4, 4'd0, 64'h55, 64'h0F, 5'd7, 0, 3, 2, 1'b0);
    run_op(1'b0, 5'd0, 4'd0, 64'd11, 64'd22, 5'd8, 0, -1, 0, 1'b0);
    run_op(1'b0, 5'd0, 4'd0, 64'd0, 64'd1, 5'd5, 0, -1, 1, 1'b1);
    run_op(1'b0, 5'd1, 4'd0, 64'd9, 64'd9, 5'd6, 0, 0, 0, 1'b0);

    // flush in IDLE blocks acceptance.
    flush = 1'b1; in_valid = 1'b1; in_is_mdu = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("idle_flush_ready", in_ready, 1'b1);
    chk("idle_flush_alu_valid", alu_valid, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      bit          m;
      int          lat, bp, vs, f, gap;
      m   = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 5);
      bp  = $urandom_range(0, 3);
      vs  = m ? lat + 1 : 2;
      f   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, vs + bp) : -1;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_in_ready", in_ready, 1'b1);
      end
      run_op(m, 5'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom), lat, f, bp, !m && ($urandom_range(0, 3) == 0));
    end

    // Reset while in MDU_WAIT.
    in_valid = 1'b1; in_is_mdu = 1'b1; in_a = 64'd3; in_b = 64'd5; in_mduop = 4'd1;
    in_aluop = 5'd3; in_rd = 5'd12;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_cnt = 0;
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_mdu_start", mdu_start, 1'b0);
    chk("mrst_alu_valid", alu_valid, 1'b0);
    chk("mrst_out_data", out_data, 64'd0);
    chk("mrst_out_rd", out_rd, 64'd0);
    chk("mrst_retire", retire_cnt, 64'd0);
    chk("mrst_opa", alu_a, 64'd0);
    chk("mrst_mduop", mdu_op, 64'd0);
    tick();
    chk("mrst_no_start", mdu_start, 1'b0);

    // Sixteen retirements wrap the 4-bit counter to zero.
    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, 5'd0, 4'd0, 64'(i), 64'd1, 5'(i), 0, -1, 0, 1'b0);
    end
    chk("wrap_retire", retire_cnt, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
